instr_fetch: RTL

Instruction fetch unit that produces the 32-bit instruction stream consumed by the decoder. Holds the PC and issues sequential word requests to instruction memory. Buffers in-order responses in a small queue and presents them with their PC over a valid/ready handshake. Branch/jump resolution later in the pipeline redirects it, flushing all buffered and in-flight instructions.

---
 rtl/instr_fetch.sv | 102 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with in-order response queue and redirect flush
// Optional IFETCH_BYPASS_EN: a response reaching an empty queue is forwarded to out in the same cycle.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_target;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW:0]   in_use;
  logic          accept;
  logic          resp_keep;
  logic          bypass;
  logic          enq;
  logic          deq;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign in_use          = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid  = !rst && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr   = pc;
  assign accept          = imem_req_valid && imem_req_ready;
  assign resp_keep       = imem_resp_valid && (drop == '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass = resp_keep && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (count != '0) || bypass;
  assign out_instr = bypass ? imem_resp_data : q_instr[rd_ptr];
  assign out_pc    = bypass ? resp_pc : q_pc[rd_ptr];
  assign deq       = (count != '0) && out_ready;
  assign enq       = resp_keep && !(bypass && out_ready);

  // resp_pc tracks the PC of the next non-dropped response; requests are sequential
  // from the last redirect, so a single incrementing pointer replaces a PC FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect) begin
      pc          <= redirect_target;
      resp_pc     <= redirect_target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      // any response this cycle retires one pending fetch, dropped or not
      drop        <= drop + outstanding - CW'(imem_resp_valid);
    end else begin
      if (accept)
        pc <= pc + 32'd4;
      if (resp_keep)
        resp_pc <= resp_pc + 32'd4;
      if (imem_resp_valid && (drop != '0))
        drop <= drop - CW'(1);
      outstanding <= outstanding + CW'(accept) - CW'(resp_keep);
      if (enq) begin
        q_instr[wr_ptr] <= imem_resp_data;
        q_pc[wr_ptr]    <= resp_pc;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (deq)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end
endmodule
